// File: rtl/spi_regfile_rw_if.sv
// SPI pin bundle between an external controller (master) and the register-file target (slave).
// Framing: ncs low brackets one frame; copi is stable around each sclk rise, cipo is valid at each sclk rise.
interface spi_regfile_rw_if;
    logic sclk;
    logic ncs;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
    modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 target decoding 16-bit frames into the PWM configuration registers, with read-back.
module spi_regfile_rw #(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_regfile_rw_if.slave        spi,
    output logic [7:0]             en_reg_out_7_0,
    output logic [7:0]             en_reg_out_15_8,
    output logic [7:0]             en_reg_pwm_7_0,
    output logic [7:0]             en_reg_pwm_15_8,
    output logic [7:0]             pwm_duty_cycle,
    output logic                   frame_err,
    output logic [1:0]             state_dbg
);
    localparam logic [6:0] WR_COUNT_ADDR = 7'h05;
    localparam logic [4:0] FRAME_BITS    = 5'd16;
    localparam logic [4:0] CNT_MAX       = 5'd17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Index SYNC_STAGES of each pipe is the edge-detect flop.
    logic [SYNC_STAGES:0] sclk_pipe, ncs_pipe, copi_pipe;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;

    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic [7:0]  rd_sh;
    logic        reading;
    logic        cipo_q;
    logic [7:0]  regs [NUM_REGS];
    logic [7:0]  wr_count;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_val;
    logic        addr_hit;

    // ncs resets low so a frame already running at reset release never shows a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_pipe <= '0;
            ncs_pipe  <= '0;
            copi_pipe <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-1:0], spi.sclk};
            ncs_pipe  <= {ncs_pipe[SYNC_STAGES-1:0], spi.ncs};
            copi_pipe <= {copi_pipe[SYNC_STAGES-1:0], spi.copi};
        end
    end

    assign sclk_rise =  sclk_pipe[SYNC_STAGES-1] & ~sclk_pipe[SYNC_STAGES];
    assign sclk_fall = ~sclk_pipe[SYNC_STAGES-1] &  sclk_pipe[SYNC_STAGES];
    assign ncs_rise  =  ncs_pipe[SYNC_STAGES-1]  & ~ncs_pipe[SYNC_STAGES];
    assign ncs_fall  = ~ncs_pipe[SYNC_STAGES-1]  &  ncs_pipe[SYNC_STAGES];
    assign copi_s    =  copi_pipe[SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (ncs_fall) state_nxt = SHIFT;
            SHIFT:   if (ncs_rise) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address of a read is complete once the 8th bit arrives on copi.
    assign rd_addr = {shreg[5:0], copi_s};

    always_comb begin
        rd_val = 8'h00;
        if (rd_addr == WR_COUNT_ADDR) rd_val = wr_count;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) rd_val = regs[i];
        end
    end

    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shreg[14:8] == 7'(i)) addr_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            rd_sh     <= '0;
            reading   <= 1'b0;
            cipo_q    <= 1'b0;
            wr_count  <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    cipo_q <= 1'b0;
                    if (ncs_fall) begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                        rd_sh   <= '0;
                        reading <= 1'b0;
                    end
                end
                SHIFT: begin
                    // A coincident ncs rise ends the frame; the sclk edge is dropped.
                    if (!ncs_rise) begin
                        if (sclk_rise) begin
                            if (bit_cnt < FRAME_BITS) shreg <= {shreg[14:0], copi_s};
                            if (bit_cnt != CNT_MAX)   bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7 && !shreg[6]) begin
                                reading <= 1'b1;
                                rd_sh   <= rd_val;
                                cipo_q  <= rd_val[7];
                            end
                        end else if (sclk_fall && reading && bit_cnt >= 5'd9) begin
                            rd_sh  <= {rd_sh[6:0], 1'b0};
                            cipo_q <= rd_sh[6];
                        end
                    end
                end
                COMMIT: begin
                    cipo_q <= 1'b0;
                    if (bit_cnt != FRAME_BITS) begin
                        frame_err <= 1'b1;
                    end else if (shreg[15] && addr_hit) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (shreg[14:8] == 7'(i)) regs[i] <= shreg[7:0];
                        end
                        wr_count <= wr_count + 8'd1;
                    end
                end
                default: cipo_q <= 1'b0;
            endcase
        end
    end

    assign spi.cipo    = cipo_q;
    assign spi.cipo_oe = (state == SHIFT);
    assign state_dbg   = state;

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];
endmodule

// File: tb/tb_spi_regfile_rw.sv
// Randomized bench for spi_regfile_rw against a frame-level register/counter model.
`timescale 1ns/1ps
module tb_spi_regfile_rw;
    localparam int NUM_REGS    = 5;
    localparam int SYNC_STAGES = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_regfile_rw_if bus ();
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       frame_err;
    logic [1:0] state_dbg;

    spi_regfile_rw #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (bus),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .frame_err       (frame_err),
        .state_dbg       (state_dbg)
    );

    // model and scoreboard
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] m_regs [NUM_REGS];
    logic [7:0] m_wc;
    logic       exp_oe, exp_err, chk_en;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [6:0] a);
        if (a < 7'(NUM_REGS)) return m_regs[a[2:0]];
        if (a == 7'h05) return m_wc;
        return 8'h00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_wc = 8'h00;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("reg00", en_reg_out_7_0,  m_regs[0]);
            check("reg01", en_reg_out_15_8, m_regs[1]);
            check("reg02", en_reg_pwm_7_0,  m_regs[2]);
            check("reg03", en_reg_pwm_15_8, m_regs[3]);
            check("reg04", pwm_duty_cycle,  m_regs[4]);
            check("cipo_oe", bus.cipo_oe, exp_oe);
            check("frame_err", frame_err, exp_err);
        end
    end

    // driver tasks
    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_clear();
        exp_oe  = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.sclk = 1'($urandom_range(0, 1));
            bus.ncs  = 1'($urandom_range(0, 1));
            bus.copi = 1'($urandom_range(0, 1));
        end
        check("rst_reg00", en_reg_out_7_0, 8'h00);
        check("rst_reg01", en_reg_out_15_8, 8'h00);
        check("rst_reg02", en_reg_pwm_7_0, 8'h00);
        check("rst_reg03", en_reg_pwm_15_8, 8'h00);
        check("rst_reg04", pwm_duty_cycle, 8'h00);
        check("rst_cipo", bus.cipo, 1'b0);
        check("rst_cipo_oe", bus.cipo_oe, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        @(negedge clk);
        bus.sclk = 1'b0;
        bus.ncs  = 1'b1;
        bus.copi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_bit(input logic b, input int half);
        bus.copi = b;
        repeat (half) @(negedge clk);
        bus.sclk = 1'b1;
        repeat (half) @(negedge clk);
        bus.sclk = 1'b0;
    endtask

    task automatic xfer(input logic [15:0] word, input int nbits, input int half, output logic [7:0] rx);
        logic       rd;
        logic [7:0] rdv;
        logic       exp_bit;
        logic [7:0] exp_rd;
        rd  = ~word[15];
        rdv = m_read(word[14:8]);
        rx  = 8'h00;
        if (rd && nbits >= 16) exp_q.push_back(rdv);
        @(negedge clk);
        bus.ncs = 1'b0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        exp_oe = 1'b1;
        for (int i = 1; i <= nbits; i++) begin
            bus.copi = (i <= 16) ? word[16-i] : 1'($urandom_range(0, 1));
            repeat (half) @(negedge clk);
            exp_bit = (rd && i >= 9 && i <= 16) ? rdv[16-i] : 1'b0;
            check("cipo_bit", bus.cipo, exp_bit);
            if (i >= 9 && i <= 16) rx = {rx[6:0], bus.cipo};
            bus.sclk = 1'b1;
            repeat (half) @(negedge clk);
            bus.sclk = 1'b0;
        end
        bus.copi = 1'b0;
        repeat (half) @(negedge clk);
        bus.ncs = 1'b1;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        exp_oe = 1'b0;
        @(posedge clk);
        if (nbits != 16) begin
            exp_err = 1'b1;
        end else if (word[15] && word[14:8] < 7'(NUM_REGS)) begin
            m_regs[word[10:8]] = word[7:0];
            m_wc = m_wc + 8'd1;
        end
        @(posedge clk);
        exp_err = 1'b0;
        repeat (half) @(negedge clk);
        if (rd && nbits >= 16) begin
            exp_rd = exp_q.pop_front();
            check("rd_data", rx, exp_rd);
        end
    endtask

    initial begin
        #5ms;
        n_fail++;
        $display("FAIL watchdog: got no finish, required finish before 5ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        logic [7:0]  rx;
        logic [6:0]  a;
        logic [15:0] mid_word;
        int          sel, nb;
        bus.sclk = 1'b0;
        bus.ncs  = 1'b1;
        bus.copi = 1'b0;
        exp_oe   = 1'b0;
        exp_err  = 1'b0;
        chk_en   = 1'b0;
        model_clear();

        apply_reset();
        chk_en = 1'b1;
        xfer(16'h0500, 16, 5, rx);
        check("rd_wc_after_reset", rx, 8'h00);

        xfer(16'h84A5, 16, 5, rx);
        check("duty_A5", pwm_duty_cycle, 8'hA5);
        check("out_lo_zero", en_reg_out_7_0, 8'h00);
        xfer(16'h0500, 16, 5, rx);
        check("rd_wc_one", rx, 8'h01);

        apply_reset();
        xfer(16'h80FF, 16, 4, rx);
        xfer(16'h823C, 16, 6, rx);
        check("out_lo_FF", en_reg_out_7_0, 8'hFF);
        xfer(16'h0200, 16, 5, rx);
        check("rd_reg02_3C", rx, 8'h3C);
        xfer(16'h0500, 16, 5, rx);
        check("rd_wc_two", rx, 8'h02);

        xfer(16'hB011, 16, 5, rx);
        xfer(16'h3000, 16, 5, rx);
        check("rd_addr30_zero", rx, 8'h00);
        xfer(16'h0500, 16, 5, rx);
        check("rd_wc_still_two", rx, 8'h02);

        xfer(16'h81FF, 11, 5, rx);
        check("abort11_out_hi", en_reg_out_15_8, 8'h00);
        xfer(16'h81FF, 17, 5, rx);
        check("len17_out_hi", en_reg_out_15_8, 8'h00);

        for (int f = 0; f < 60; f++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = 7'(sel);
            else if (sel == 7) a = 7'h30;
            else               a = 7'($urandom_range(0, 127));
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : 16;
            xfer({1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255))}, nb, $urandom_range(4, 6), rx);
        end

        apply_reset();
        for (int f = 0; f < 256; f++) begin
            xfer({1'b1, 4'b0000, 3'($urandom_range(0, 4)), 8'($urandom_range(0, 255))}, 16, 4, rx);
        end
        xfer(16'h0500, 16, 4, rx);
        check("rd_wc_wrapped", rx, 8'h00);

        mid_word = 16'h8155;
        @(negedge clk);
        bus.ncs = 1'b0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        exp_oe = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) pulse_bit(mid_word[15-i], 5);
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_clear();
        exp_oe  = 1'b0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 6; i < 16; i++) pulse_bit(mid_word[15-i], 5);
        repeat (5) @(negedge clk);
        bus.ncs = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_reset_out_hi", en_reg_out_15_8, 8'h00);
        xfer(16'h8377, 16, 5, rx);
        check("post_reset_pwm_hi", en_reg_pwm_15_8, 8'h77);
        xfer(16'h0500, 16, 5, rx);
        check("post_reset_wc", rx, 8'h01);

        chk_en = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
